// File: rtl/rv6_bus_pkg.sv
// Shared types and defaults for the instruction/data memory-bus arbiter.
package rv6_bus_pkg;
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_LINE_W = 1024;
  localparam int LINE_BYTES = DEF_LINE_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; req/gnt bit 0 is the instruction side, bit 1 the data side.
module arb_rr2
  import rv6_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  owner_t last_owner_reg;
  logic   last_is_d;

  assign last_is_d = (last_owner_reg == OWN_D);

  // On contention a side wins only if it was not the previous owner.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pick
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_is_d != 1'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_reg <= OWN_D;
    end else if (advance && (|req)) begin
      last_owner_reg <= gnt[1] ? OWN_D : OWN_I;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one cache-line memory port between the instruction-fetch and data buses,
// one latched transaction at a time, returning the line with a one-cycle strobe.
module mem_bus_arbiter
  import rv6_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic              b_rd_i,
  output logic [LINE_W-1:0] b_data_i,
  output logic              b_dv_i,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_data_out,
  output logic [LINE_W-1:0] b_data_in,
  output logic              b_dv,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [LINE_W-1:0] m_data_out,
  input  logic [LINE_W-1:0] m_data_in,
  input  logic              m_dv
);
  arb_state_t        state_reg;
  owner_t            owner_reg;
  op_t               op_reg;
  logic [ADDR_W-1:0] m_addr_reg;
  logic              m_rd_reg;
  logic              m_wr_reg;
  logic [LINE_W-1:0] m_data_out_reg;
  logic [LINE_W-1:0] line_buf_reg;
  logic              b_dv_i_reg;
  logic              b_dv_reg;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       advance;

  assign req     = {b_rd | b_wr, b_rd_i};
  assign advance = (state_reg == IDLE);

  arb_rr2 u_arb_rr2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_I;
      op_reg         <= OP_RD;
      m_addr_reg     <= '0;
      m_rd_reg       <= 1'b0;
      m_wr_reg       <= 1'b0;
      m_data_out_reg <= '0;
      line_buf_reg   <= '0;
      b_dv_i_reg     <= 1'b0;
      b_dv_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (gnt[1]) begin
            state_reg  <= BUSY;
            owner_reg  <= OWN_D;
            m_addr_reg <= b_addr;
            // A simultaneous read and write from the data side resolves as a write.
            if (b_wr) begin
              op_reg         <= OP_WR;
              m_wr_reg       <= 1'b1;
              m_data_out_reg <= b_data_out;
            end else begin
              op_reg   <= OP_RD;
              m_rd_reg <= 1'b1;
            end
          end else if (gnt[0]) begin
            state_reg  <= BUSY;
            owner_reg  <= OWN_I;
            op_reg     <= OP_RD;
            m_addr_reg <= b_addr_i;
            m_rd_reg   <= 1'b1;
          end
        end
        BUSY: begin
          if (m_dv) begin
            state_reg  <= RESP;
            m_rd_reg   <= 1'b0;
            m_wr_reg   <= 1'b0;
            b_dv_i_reg <= (owner_reg == OWN_I);
            b_dv_reg   <= (owner_reg == OWN_D);
            if (op_reg == OP_RD) begin
              line_buf_reg <= m_data_in;
            end
          end
        end
        RESP: begin
          state_reg  <= IDLE;
          b_dv_i_reg <= 1'b0;
          b_dv_reg   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_addr     = m_addr_reg;
  assign m_rd       = m_rd_reg;
  assign m_wr       = m_wr_reg;
  assign m_data_out = m_data_out_reg;
  assign b_dv_i     = b_dv_i_reg;
  assign b_dv       = b_dv_reg;

  // The line buffer is only visible to its owner during the response cycle of a read.
  assign b_data_i  = (state_reg == RESP && owner_reg == OWN_I && op_reg == OP_RD) ? line_buf_reg : '0;
  assign b_data_in = (state_reg == RESP && owner_reg == OWN_D && op_reg == OP_RD) ? line_buf_reg : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected memory requests and
// responses into queues, independent monitors pop and compare them.
module tb_mem_bus_arbiter;
  import rv6_bus_pkg::*;

  localparam int AW = 64;
  localparam int LW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] b_addr_i = '0;
  logic          b_rd_i = 1'b0;
  logic [LW-1:0] b_data_i;
  logic          b_dv_i;
  logic [AW-1:0] b_addr = '0;
  logic          b_rd = 1'b0;
  logic          b_wr = 1'b0;
  logic [LW-1:0] b_data_out = '0;
  logic [LW-1:0] b_data_in;
  logic          b_dv;
  logic [AW-1:0] m_addr;
  logic          m_rd;
  logic          m_wr;
  logic [LW-1:0] m_data_out;
  logic [LW-1:0] m_data_in = '0;
  logic          m_dv = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .b_addr_i   (b_addr_i),
    .b_rd_i     (b_rd_i),
    .b_data_i   (b_data_i),
    .b_dv_i     (b_dv_i),
    .b_addr     (b_addr),
    .b_rd       (b_rd),
    .b_wr       (b_wr),
    .b_data_out (b_data_out),
    .b_data_in  (b_data_in),
    .b_dv       (b_dv),
    .m_addr     (m_addr),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_dv       (m_dv)
  );

  typedef struct {
    logic          own_d;
    logic [LW-1:0] data;
  } resp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void chk_line(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual_hi=%h actual_lo=%h required_hi=%h required_lo=%h",
               name, act[LW-1 -: 64], act[63:0], exp[LW-1 -: 64], exp[63:0]);
    end
  endfunction

  function automatic logic [LW-1:0] fill(logic [7:0] b);
    return {LINE_BYTES{b}};
  endfunction

  function automatic logic [LW-1:0] ramp();
    logic [LW-1:0] r;
    for (int i = 0; i < LINE_BYTES; i++) r[i*8 +: 8] = 8'(i);
    return r;
  endfunction

  // Response monitor: every strobe must match the head of the response queue.
  resp_t mon_r;
  always @(negedge clk) begin
    if (b_dv_i || b_dv) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual b_dv_i=%0b b_dv=%0b required none", b_dv_i, b_dv);
      end else begin
        mon_r = resp_q.pop_front();
        chk("strobe_owner", {62'd0, b_dv_i, b_dv}, mon_r.own_d ? 64'd1 : 64'd2);
        chk_line("resp_data", mon_r.own_d ? b_data_in : b_data_i, mon_r.data);
        chk_line("other_data_zero", mon_r.own_d ? b_data_i : b_data_in, '0);
        $display("resp %s data_lo=%h", mon_r.own_d ? "D" : "I", mon_r.data[63:0]);
      end
    end else begin
      chk_line("b_data_i_idle", b_data_i, '0);
      chk_line("b_data_in_idle", b_data_in, '0);
    end
  end

  // Memory-request monitor: each new m_rd/m_wr must match the head of the request queue.
  mreq_t         mon_m;
  logic          mreq_prev = 1'b0;
  logic [AW-1:0] mon_addr = '0;
  always @(negedge clk) begin
    chk("m_rd_m_wr_exclusive", {63'd0, m_rd & m_wr}, 64'd0);
    if ((m_rd || m_wr) && !mreq_prev) begin
      mon_addr = m_addr;
      if (mreq_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mem_req actual addr=%h rd=%0b wr=%0b required none", m_addr, m_rd, m_wr);
      end else begin
        mon_m = mreq_q.pop_front();
        chk("mem_rd", {63'd0, m_rd}, {63'd0, ~mon_m.wr});
        chk("mem_wr", {63'd0, m_wr}, {63'd0, mon_m.wr});
        chk("mem_addr", m_addr, mon_m.addr);
        if (mon_m.wr) chk_line("mem_wdata", m_data_out, mon_m.data);
        $display("mreq %s addr=%h", mon_m.wr ? "WR" : "RD", mon_m.addr);
      end
    end else if ((m_rd || m_wr) && mreq_prev) begin
      chk("m_addr_stable", m_addr, mon_addr);
    end
    mreq_prev = m_rd || m_wr;
  end

  always @(negedge clk) begin
    if (rst_n) assert (!(b_rd && b_wr)) else $error("illegal: b_rd and b_wr both high");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int w);
    w = 0;
    while (!(m_rd || m_wr) && w < 50) begin
      tick();
      w++;
    end
    if (!(m_rd || m_wr)) begin
      checks++;
      errors++;
      $display("FAIL mem_req_timeout actual none required m_rd or m_wr within 50 cycles");
    end
  endtask

  task automatic pulse_dv(input int lat, input logic [LW-1:0] data);
    repeat (lat - 1) tick();
    m_dv = 1'b1;
    m_data_in = data;
    tick();
    m_dv = 1'b0;
    m_data_in = ~data;
  endtask

  task automatic check_outputs_zero(string tag);
    chk({tag, "_m_rd"}, {63'd0, m_rd}, 64'd0);
    chk({tag, "_m_wr"}, {63'd0, m_wr}, 64'd0);
    chk({tag, "_m_addr"}, m_addr, 64'd0);
    chk_line({tag, "_m_data_out"}, m_data_out, '0);
    chk({tag, "_b_dv_i"}, {63'd0, b_dv_i}, 64'd0);
    chk({tag, "_b_dv"}, {63'd0, b_dv}, 64'd0);
    chk_line({tag, "_b_data_i"}, b_data_i, '0);
    chk_line({tag, "_b_data_in"}, b_data_in, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int w;
  logic [LW-1:0] pat;

  initial begin
    // Reset state
    repeat (2) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // I-only read, memory answers 4 cycles after m_rd
    b_addr_i = 64'h8000_0000;
    mreq_q.push_back('{1'b0, 64'h8000_0000, '0});
    resp_q.push_back('{1'b0, fill(8'hA5)});
    b_rd_i = 1'b1;
    wait_req(w);
    chk("i_rd_grant_latency", 64'(w), 64'd1);
    pulse_dv(4, fill(8'hA5));
    chk("i_rd_strobe", {62'd0, b_dv_i, b_dv}, 64'd2);
    b_rd_i = 1'b0;
    repeat (2) tick();

    // D write of a byte ramp
    b_addr = 64'h40;
    b_data_out = ramp();
    mreq_q.push_back('{1'b1, 64'h40, ramp()});
    resp_q.push_back('{1'b1, '0});
    b_wr = 1'b1;
    wait_req(w);
    chk("d_wr_grant_latency", 64'(w), 64'd1);
    pulse_dv(3, fill(8'h3C));
    chk("d_wr_strobe", {62'd0, b_dv_i, b_dv}, 64'd1);
    b_wr = 1'b0;
    repeat (2) tick();

    // Simultaneous requests from reset: I first, D next
    do_reset();
    b_addr_i = 64'h8000_0080;
    b_addr = 64'h100;
    mreq_q.push_back('{1'b0, 64'h8000_0080, '0});
    mreq_q.push_back('{1'b0, 64'h100, '0});
    resp_q.push_back('{1'b0, fill(8'h11)});
    resp_q.push_back('{1'b1, fill(8'h22)});
    b_rd_i = 1'b1;
    b_rd = 1'b1;
    wait_req(w);
    pulse_dv(2, fill(8'h11));
    chk("pair_first_strobe", {62'd0, b_dv_i, b_dv}, 64'd2);
    b_rd_i = 1'b0;
    wait_req(w);
    chk("pair_gap_cycles", 64'(w), 64'd2);
    pulse_dv(2, fill(8'h22));
    chk("pair_second_strobe", {62'd0, b_dv_i, b_dv}, 64'd1);
    b_rd = 1'b0;
    repeat (2) tick();

    // Both held continuously: grants alternate I, D, I, D
    b_rd_i = 1'b1;
    b_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pat = fill(8'(8'h31 + i));
      mreq_q.push_back('{1'b0, (i % 2 == 0) ? 64'h8000_0080 : 64'h100, '0});
      resp_q.push_back('{(i % 2 == 1), pat});
      wait_req(w);
      pulse_dv(1 + i, pat);
      chk("alt_strobe", {62'd0, b_dv_i, b_dv}, (i % 2 == 0) ? 64'd2 : 64'd1);
    end
    b_rd_i = 1'b0;
    b_rd = 1'b0;
    repeat (3) tick();

    // Stray m_dv in IDLE, then m_dv held through RESP
    m_dv = 1'b1;
    m_data_in = fill(8'h77);
    repeat (3) tick();
    m_dv = 1'b0;
    chk("stray_idle_m_rd", {63'd0, m_rd}, 64'd0);
    chk("stray_idle_m_wr", {63'd0, m_wr}, 64'd0);
    b_addr_i = 64'h8000_0200;
    mreq_q.push_back('{1'b0, 64'h8000_0200, '0});
    resp_q.push_back('{1'b0, fill(8'h55)});
    b_rd_i = 1'b1;
    wait_req(w);
    m_dv = 1'b1;
    m_data_in = fill(8'h55);
    tick();
    b_rd_i = 1'b0;
    m_data_in = fill(8'h66);
    tick();
    m_dv = 1'b0;
    repeat (3) tick();
    chk("stray_resp_m_rd", {63'd0, m_rd}, 64'd0);

    // Reset while BUSY on a D read, late m_dv afterwards, then a fresh request
    b_addr = 64'h200;
    mreq_q.push_back('{1'b0, 64'h200, '0});
    b_rd = 1'b1;
    wait_req(w);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    b_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m_dv = 1'b1;
    m_data_in = fill(8'hEE);
    tick();
    m_dv = 1'b0;
    repeat (2) tick();
    chk("late_dv_b_dv", {63'd0, b_dv}, 64'd0);
    b_addr = 64'h300;
    mreq_q.push_back('{1'b0, 64'h300, '0});
    resp_q.push_back('{1'b1, fill(8'h88)});
    b_rd = 1'b1;
    wait_req(w);
    chk("post_rst_grant_latency", 64'(w), 64'd1);
    pulse_dv(2, fill(8'h88));
    chk("post_rst_strobe", {62'd0, b_dv_i, b_dv}, 64'd1);
    b_rd = 1'b0;
    repeat (2) tick();

    // I request raised and dropped entirely inside a D transaction
    b_addr = 64'h400;
    mreq_q.push_back('{1'b0, 64'h400, '0});
    resp_q.push_back('{1'b1, fill(8'h99)});
    b_rd = 1'b1;
    wait_req(w);
    b_addr_i = 64'h8000_1000;
    b_rd_i = 1'b1;
    repeat (2) tick();
    b_rd_i = 1'b0;
    pulse_dv(2, fill(8'h99));
    chk("glitch_d_strobe", {62'd0, b_dv_i, b_dv}, 64'd1);
    b_rd = 1'b0;
    repeat (4) tick();
    chk("glitch_no_i_m_rd", {63'd0, m_rd}, 64'd0);

    repeat (2) tick();
    chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
    chk("mreq_q_drained", 64'(mreq_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one cache-line memory port between the hart's instruction-fetch bus (read-only) and data bus (read/write).
- Sits between `hart` and the memory model/controller.
- Serializes line transactions with 2-way round-robin arbitration and latches each winning request.
- Buffers the returned line and replays the data-valid strobe to the owning requester.

Parameters:
- ADDR_W, 64, byte address width on all ports
- LINE_W, 1024, cache-line width in bits (128 bytes)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- b_addr_i  input  ADDR_W  instruction-side line address
- b_rd_i  input  1  instruction-side read request; level, held until b_dv_i
- b_data_i  output  LINE_W  instruction-side read line
- b_dv_i  output  1  instruction-side completion strobe, one cycle
- b_addr  input  ADDR_W  data-side line address
- b_rd  input  1  data-side read request; level, held until b_dv
- b_wr  input  1  data-side write request; level, held until b_dv
- b_data_out  input  LINE_W  data-side write line
- b_data_in  output  LINE_W  data-side read line
- b_dv  output  1  data-side completion strobe (read or write), one cycle
- m_addr  output  ADDR_W  memory line address
- m_rd  output  1  memory read; held until m_dv
- m_wr  output  1  memory write; held until m_dv
- m_data_out  output  LINE_W  memory write line
- m_data_in  input  LINE_W  memory read line, valid when m_dv=1
- m_dv  input  1  memory completion strobe (read data valid / write done)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_owner=D.
  - All outputs are 0: m_rd, m_wr, m_addr, m_data_out, b_dv_i, b_dv, b_data_i, b_data_in.
  - Line buffer cleared. No outputs are ever driven Z.
- FSM states: IDLE, BUSY, RESP. Owner register holds I or D. Op register holds RD or WR.
- IDLE:
  - Samples b_rd_i and (b_rd | b_wr).
  - One requester: grant it.
  - Both requesting: grant the requester that is not last_owner.
  - On grant, at the next edge:
    - Latch address into m_addr.
    - For a D write, latch b_data_out into m_data_out.
    - Assert m_rd or m_wr; set owner and op; update last_owner; go to BUSY.
- BUSY:
  - m_rd/m_wr and m_addr stay stable; upstream inputs are ignored.
  - On m_dv=1 at an edge:
    - Drop m_rd/m_wr.
    - For a read, capture m_data_in into the line buffer.
    - Go to RESP.
  - There is no timeout; BUSY waits indefinitely.
- RESP (exactly one cycle):
  - Owner's strobe is 1 (b_dv_i or b_dv).
  - Owner's data output presents the line buffer for a read.
  - Next state is IDLE unconditionally. New requests are not sampled in RESP.
- Data outputs b_data_i and b_data_in are 0 outside their owner's RESP cycle.
- Minimum latency, request asserted to strobe: 1 cycle (grant) + memory cycles up to and including the m_dv edge + 1 cycle (RESP). Back-to-back transactions are separated by ≥1 IDLE cycle.
- Requesters:
  - Must drop their request by the edge following their strobe.
  - A request dropped before grant is never issued.
  - After grant, the transaction completes regardless of the upstream request level.
- b_rd and b_wr both high in IDLE: illegal. The bench flags it by assertion; RTL treats it as a write.
- m_dv while in IDLE or RESP: ignored (covers stale completions after reset).
- Reset mid-BUSY: returns to IDLE immediately and drops m_rd/m_wr. The memory side must tolerate an abandoned request.
- Address is passed through unmodified; no base offset is applied and no alignment check is made.

Decomposition:
- Package rv6_bus_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP}
  - owner_t enum {OWN_I, OWN_D}
  - op_t enum {OP_RD, OP_WR}
  - localparam LINE_BYTES = LINE_W/8
- One sub-module: arb_rr2, a 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: gnt[1:0] (combinational) and a registered last_owner update qualified by an advance signal.

Test Plan:
- I-only read, addr 0x8000_0000, memory returns m_dv 4 cycles after m_rd with pattern 0xA5… → m_rd high 1 cycle after b_rd_i, m_addr=0x8000_0000; b_dv_i one cycle exactly 1 cycle after m_dv; b_data_i equals pattern; b_dv stays 0.
- D write, addr 0x40, b_data_out byte i = i → m_wr with m_data_out identical; after m_dv, b_dv pulses once; m_rd never asserted; b_data_in stays 0.
- Simultaneous b_rd_i (0x8000_0080) and b_rd (0x100) from reset → I granted first (last_owner=D), then D in a later IDLE. Repeat both held continuously → grants alternate I, D, I, D.
- m_dv held/pulsed during IDLE and RESP with no request → no strobes, no state change, line buffer unchanged.
- rst_n dropped while BUSY on a D read → m_rd=0 and all outputs 0 asynchronously. Late m_dv after rst_n=1 → no b_dv. Fresh request afterwards completes normally.
- Request glitch: b_rd_i high for 0 grant cycles (dropped while D transaction BUSY) → no I transaction issued; D completes unaffected.
